// File: rtl/recon_blk_assembler.sv
// Collects three 2x8 component blocks (Y/Co/Cg or Y/Cb/Cr) into one packed 2x8x3 block and tracks slice position.
// Optional output clipping is enabled with `define RECON_CLIP_EN.
module recon_blk_assembler #(
    parameter int MAX_SLICE_WIDTH  = 2560,
    parameter int MAX_SLICE_HEIGHT = 4096
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [1:0]                          csc,
    input  logic [1:0]                          chroma_format,
    input  logic [12:0]                         maxPoint,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
    input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
    input  logic                                comp_valid,
    input  logic [1:0]                          comp_idx,
    input  logic [16*14-1:0]                    comp_data,
    output logic                                comp_ready,
    output logic                                pReconBlk_valid,
    output logic [2*8*3*14-1:0]                 pReconBlk_p,
    output logic                                blk_sos,
    output logic                                blk_eos,
    output logic                                order_err
);

    localparam int SW_W  = $clog2(MAX_SLICE_WIDTH);
    localparam int SH_W  = $clog2(MAX_SLICE_HEIGHT);
    localparam int COL_W = SW_W - 3;
    localparam int ROW_W = SH_W - 1;

    typedef enum logic [1:0] {WAIT0, WAIT1, WAIT2} state_t;

    state_t                     state_q, state_d;
    logic                       load0, load1, emit, err_set;
    logic [16*14-1:0]           buf0_q, buf1_q;
    logic [COL_W-1:0]           col_q;
    logic [ROW_W-1:0]           row_q;
    logic                       last_col, last_row;
    logic [2*8*3*14-1:0]        assembled;

    assign comp_ready = ~flush;
    assign last_col   = (col_q == slice_width[SW_W-1:3] - COL_W'(1));
    assign last_row   = (row_q == slice_height[SH_W-1:1] - ROW_W'(1));

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        load0   = 1'b0;
        load1   = 1'b0;
        emit    = 1'b0;
        err_set = 1'b0;
        if (flush) begin
            state_d = WAIT0;
        end else if (comp_valid) begin
            if (state_q == WAIT0 && comp_idx == 2'd0) begin
                load0   = 1'b1;
                state_d = WAIT1;
            end else if (state_q == WAIT1 && comp_idx == 2'd1) begin
                load1   = 1'b1;
                state_d = WAIT2;
            end else if (state_q == WAIT2 && comp_idx == 2'd2) begin
                emit    = 1'b1;
                state_d = WAIT0;
            end else begin
                // Out of order: a fresh comp 0 starts a new block, anything else restarts.
                err_set = 1'b1;
                load0   = (comp_idx == 2'd0);
                state_d = (comp_idx == 2'd0) ? WAIT1 : WAIT0;
            end
        end
    end

`ifdef RECON_CLIP_EN
    function automatic logic [13:0] clip(input logic [13:0] s, input logic signed [14:0] lo,
                                         input logic signed [14:0] hi);
        logic signed [14:0] x;
        x = {s[13], s};
        if (x < lo) return lo[13:0];
        if (x > hi) return hi[13:0];
        return s;
    endfunction
`endif

    always_comb begin
        logic [16*14-1:0]   src;
        logic [13:0]        s;
        logic signed [14:0] hi, lo;
        assembled = '0;
        hi = {2'b00, maxPoint};
        for (int cp = 0; cp < 3; cp++) begin
            src = (cp == 0) ? buf0_q : (cp == 1) ? buf1_q : comp_data;
            lo  = (cp != 0 && csc == 2'd1) ? -(hi + 15'sd1) : 15'sd0;
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 8; c++) begin
                    s = src[(r*8+c)*14 +: 14];
`ifdef RECON_CLIP_EN
                    s = clip(s, lo, hi);
`endif
                    if (cp != 0 && ((chroma_format == 2'd1 && c >= 4) ||
                                    (chroma_format == 2'd2 && (c >= 4 || r == 1))))
                        s = '0;
                    assembled[(cp*16+r*8+c)*14 +: 14] = s;
                end
            end
        end
    end

    logic unused_cfg;
`ifdef RECON_CLIP_EN
    assign unused_cfg = ^{slice_width[2:0], slice_height[0]};
`else
    assign unused_cfg = ^{slice_width[2:0], slice_height[0], csc, maxPoint, 15'(0)};
`endif

    // NOTE: sample buffers are only read after being written, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load0) buf0_q <= comp_data;
        if (load1) buf1_q <= comp_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= WAIT0;
            col_q           <= '0;
            row_q           <= '0;
            pReconBlk_valid <= 1'b0;
            pReconBlk_p     <= '0;
            blk_sos         <= 1'b0;
            blk_eos         <= 1'b0;
            order_err       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pReconBlk_valid <= emit;
            if (flush) order_err <= 1'b0;
            else if (err_set) order_err <= 1'b1;
            if (flush) begin
                col_q <= '0;
                row_q <= '0;
            end else if (emit) begin
                pReconBlk_p <= assembled;
                blk_sos     <= (col_q == '0) && (row_q == '0);
                blk_eos     <= last_col && last_row;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_recon_blk_assembler.sv
// Randomized self-checking bench for recon_blk_assembler with a transfer-level reference model.
// Honours `define RECON_CLIP_EN when compiled with it.
module tb_recon_blk_assembler;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic [1:0]     csc = 2'd2;
    logic [1:0]     chroma_format = 2'd0;
    logic [12:0]    maxPoint = 13'd8191;
    logic [11:0]    slice_width = 12'd16;
    logic [11:0]    slice_height = 12'd4;
    logic           comp_valid = 1'b0;
    logic [1:0]     comp_idx = 2'd0;
    logic [223:0]   comp_data = '0;
    logic           comp_ready;
    logic           pReconBlk_valid;
    logic [671:0]   pReconBlk_p;
    logic           blk_sos, blk_eos, order_err;

    recon_blk_assembler dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .csc(csc), .chroma_format(chroma_format),
        .maxPoint(maxPoint), .slice_width(slice_width), .slice_height(slice_height),
        .comp_valid(comp_valid), .comp_idx(comp_idx), .comp_data(comp_data),
        .comp_ready(comp_ready), .pReconBlk_valid(pReconBlk_valid), .pReconBlk_p(pReconBlk_p),
        .blk_sos(blk_sos), .blk_eos(blk_eos), .order_err(order_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [671:0] got, input logic [671:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: which component is expected next, stored component data, slice position.
    int           m_next, m_col, m_row;
    logic [223:0] m_buf [3];
    bit           m_err, m_valid, m_sos, m_eos;
    logic [671:0] m_p;

    function automatic logic [13:0] exp_sample(int cp, int r, int c, logic [13:0] v);
        int x, mp, lo;
        x  = int'($signed(v));
        mp = int'(maxPoint);
        if (cp != 0 && ((chroma_format == 2'd1 && c >= 4) ||
                        (chroma_format == 2'd2 && (c >= 4 || r == 1))))
            return 14'd0;
`ifdef RECON_CLIP_EN
        lo = (cp != 0 && csc == 2'd1) ? -(mp + 1) : 0;
        if (x < lo) x = lo;
        if (x > mp) x = mp;
`else
        lo = mp;
`endif
        return 14'(x);
    endfunction

    task automatic model_emit();
        for (int cp = 0; cp < 3; cp++)
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 8; c++)
                    m_p[(cp*16+r*8+c)*14 +: 14] = exp_sample(cp, r, c, m_buf[cp][(r*8+c)*14 +: 14]);
        m_sos   = (m_col == 0 && m_row == 0);
        m_eos   = (m_col == int'(slice_width) / 8 - 1) && (m_row == int'(slice_height) / 2 - 1);
        m_valid = 1'b1;
        m_col++;
        if (m_col == int'(slice_width) / 8) begin
            m_col = 0;
            m_row++;
            if (m_row == int'(slice_height) / 2) m_row = 0;
        end
    endtask

    task automatic model_reset();
        m_next = 0; m_col = 0; m_row = 0; m_err = 0;
        m_valid = 0; m_sos = 0; m_eos = 0; m_p = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 672'(pReconBlk_valid), 672'(m_valid));
        check({tag, ".err"},   672'(order_err), 672'(m_err));
        check({tag, ".p"},     pReconBlk_p, m_p);
        check({tag, ".sos"},   672'(blk_sos), 672'(m_sos));
        check({tag, ".eos"},   672'(blk_eos), 672'(m_eos));
    endtask

    // One clock cycle of stimulus, model update and output comparison.
    task automatic step(input bit v, input int idx, input logic [223:0] d, input bit fl, input string tag);
        @(negedge clk);
        comp_valid = v; comp_idx = 2'(idx); comp_data = d; flush = fl;
        #1 check({tag, ".ready"}, 672'(comp_ready), 672'(!fl));
        m_valid = 1'b0;
        if (fl) begin
            m_next = 0; m_col = 0; m_row = 0; m_err = 0;
        end else if (v) begin
            if (idx == m_next) begin
                m_buf[idx] = d;
                if (idx == 2) model_emit();
                m_next = (idx + 1) % 3;
            end else begin
                m_err = 1'b1;
                if (idx == 0) m_buf[0] = d;
                m_next = (idx == 0) ? 1 : 0;
            end
        end
        @(posedge clk);
        #1 check_outputs(tag);
    endtask

    function automatic logic [223:0] fill(int val);
        logic [223:0] d;
        for (int i = 0; i < 16; i++) d[i*14 +: 14] = 14'(val);
        return d;
    endfunction

    function automatic logic [223:0] rand_data();
        logic [223:0] d;
        for (int i = 0; i < 16; i++) d[i*14 +: 14] = 14'($urandom);
        return d;
    endfunction

    task automatic send_block(input logic [223:0] d0, d1, d2, input string tag);
        step(1, 0, d0, 0, tag);
        step(1, 1, d1, 0, tag);
        step(1, 2, d2, 0, tag);
        step(0, 0, '0, 0, tag);
    endtask

    initial begin
        logic [13:0] y_exp, c_exp;
        model_reset();
        #12;
        check_outputs("reset");
        rst_n = 1'b1;

        // Basic 4:4:4 block, all samples 100.
        send_block(fill(100), fill(100), fill(100), "basic");
        check("basic.first", 672'(pReconBlk_p[13:0]), 672'(14'd100));
        check("basic.last",  672'(pReconBlk_p[47*14 +: 14]), 672'(14'd100));

        // Four blocks of a 16x4 slice: sos on the first, eos on the last, then wrap.
        step(0, 0, '0, 1, "slice_flush");
        for (int b = 0; b < 4; b++) send_block(rand_data(), rand_data(), rand_data(), "slice");
        send_block(rand_data(), rand_data(), rand_data(), "slice_wrap");
        check("slice_wrap.sos", 672'(blk_sos), 672'(1'b1));

        // Out-of-order comp 2 after comp 0, then a clean block.
        step(1, 0, fill(5), 0, "order");
        step(1, 2, fill(6), 0, "order");
        check("order.err", 672'(order_err), 672'(1'b1));
        send_block(fill(1), fill(2), fill(3), "order_recover");

        // Clipping corner: luma 1500, chroma -2000 with maxPoint 1023, YCoCg.
        maxPoint = 13'd1023; csc = 2'd1;
        send_block(fill(1500), fill(-2000), fill(0), "clip");
`ifdef RECON_CLIP_EN
        y_exp = 14'd1023; c_exp = -14'sd1024;
`else
        y_exp = 14'd1500; c_exp = -14'sd2000;
`endif
        check("clip.y",  672'(pReconBlk_p[13:0]), 672'(y_exp));
        check("clip.co", 672'(pReconBlk_p[16*14 +: 14]), 672'(c_exp));

        // 4:2:0 placement, all samples 7.
        maxPoint = 13'd8191; csc = 2'd2; chroma_format = 2'd2;
        send_block(fill(7), fill(7), fill(7), "c420");
        check("c420.y_r1c7",  672'(pReconBlk_p[15*14 +: 14]), 672'(14'd7));
        check("c420.cb_r0c3", 672'(pReconBlk_p[(16+3)*14 +: 14]), 672'(14'd7));
        check("c420.cb_r0c4", 672'(pReconBlk_p[(16+4)*14 +: 14]), 672'(14'd0));
        check("c420.cr_r1c0", 672'(pReconBlk_p[(32+8)*14 +: 14]), 672'(14'd0));
        chroma_format = 2'd0;

        // Flush together with comp 2 after 0 and 1 were accepted.
        step(1, 0, fill(9), 0, "flush");
        step(1, 1, fill(9), 0, "flush");
        step(1, 2, fill(9), 1, "flush");
        send_block(fill(4), fill(4), fill(4), "after_flush");
        check("after_flush.sos", 672'(blk_sos), 672'(1'b1));

        // Reset in the middle of a block.
        step(1, 0, fill(11), 0, "midreset");
        step(1, 1, fill(11), 0, "midreset");
        @(negedge clk);
        comp_valid = 1'b0; rst_n = 1'b0;
        model_reset();
        #2 check_outputs("midreset.low");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 2, fill(11), 0, "midreset.orphan");
        send_block(fill(12), fill(13), fill(14), "midreset.after");

        // Randomized traffic: mostly ordered components, occasional flush and config changes.
        step(0, 0, '0, 1, "rand_init");
        for (int i = 0; i < 3000; i++) begin
            bit fl, v;
            int idx;
            fl  = ($urandom_range(0, 99) < 3);
            v   = ($urandom_range(0, 99) < 75);
            idx = ($urandom_range(0, 99) < 85) ? m_next : int'($urandom_range(0, 3));
            if (fl) begin
                slice_width  = 12'(8 * $urandom_range(1, 3));
                slice_height = 12'(2 * $urandom_range(1, 2));
            end
            if ($urandom_range(0, 99) < 5) begin
                chroma_format = 2'($urandom_range(0, 2));
                csc           = 2'($urandom_range(1, 2));
                maxPoint      = 13'($urandom_range(0, 8191));
            end
            step(v, idx, rand_data(), fl, "rand");
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
